// File: rtl/trig_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : trig_pkg
//  Description : Shared definitions for the trig angle finder: controller
//                state encoding, turn-size derivation and the elaboration-time
//                arctangent constant generator used by CORDIC blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package trig_pkg;

    // Controller states of the iterative vectoring engine
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ROTATE = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam real C_PI = 3.14159265358979323846;

    // Number of angle codes in one full turn
    function automatic int count_of(input int angle_width);
        return 1 << angle_width;
    endfunction

    // atan(2^-i) expressed in angle codes with GUARD extra fractional bits,
    // rounded to nearest (the real-to-integer cast rounds)
    function automatic longint atan_code(input int i, input int angle_width, input int guard);
        real r;
        r = $atan(2.0 ** real'(-i)) * real'(count_of(angle_width))
            * (2.0 ** real'(guard)) / (2.0 * C_PI);
        return longint'(r);
    endfunction

endpackage
`default_nettype wire

// File: rtl/atan_rom.sv
`default_nettype none
// ============================================================================
//  Module      : atan_rom
//  Description : Combinational table of CORDIC micro-rotation angles in angle
//                codes with guard bits; indexed by the iteration number.
//  Revision    : 1.0 - initial release
// ============================================================================
module atan_rom
    import trig_pkg::*;
#(
    parameter int ANGLE_WIDTH = 10,
    parameter int GUARD       = 4,
    parameter int ITERATIONS  = ANGLE_WIDTH + 2,
    localparam int IW         = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1,
    localparam int ZW         = ANGLE_WIDTH + GUARD
) (
    input  logic [IW-1:0] i,
    output logic [ZW-1:0] atan_i
);

    logic [ZW-1:0] w_tab [ITERATIONS];

    for (genvar g = 0; g < ITERATIONS; g++) begin : g_tab
        assign w_tab[g] = ZW'(atan_code(g, ANGLE_WIDTH, GUARD));
    end

    // Select the entry for the current iteration; out-of-range indices give 0
    always_comb begin
        atan_i = '0;
        for (int k = 0; k < ITERATIONS; k++) begin
            if (i == IW'(k)) begin
                atan_i = w_tab[k];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/trig_angle_finder.sv
`default_nettype none
// ============================================================================
//  Module      : trig_angle_finder
//  Description : Converts a signed (sin, cos) pair into the trig-table angle
//                code that produces it, using an iterative vectoring CORDIC
//                (one micro-rotation per clock) behind start/ready/valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_angle_finder
    import trig_pkg::*;
#(
    parameter int VALUE_WIDTH = 32,
    parameter int ANGLE_WIDTH = 10,
    parameter int GUARD       = 4,
    parameter int ITERATIONS  = ANGLE_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic signed [VALUE_WIDTH-1:0] sin_in,
    input  logic signed [VALUE_WIDTH-1:0] cos_in,
    output logic                          ready,
    output logic                          valid,
    output logic [ANGLE_WIDTH-1:0]        angle_out
);

    // Two extra bits absorb negation of the most-negative input and CORDIC gain
    localparam int XW = VALUE_WIDTH + 2;
    localparam int ZW = ANGLE_WIDTH + GUARD;
    localparam int IW = (ITERATIONS > 1) ? $clog2(ITERATIONS) : 1;

    // Half a turn in accumulator units, and half an output LSB for rounding
    localparam logic [ZW-1:0] C_Z_HALF  = {1'b1, {(ZW-1){1'b0}}};
    localparam logic [ZW-1:0] C_Z_ROUND = ZW'(2 ** (GUARD - 1));

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
    logic [ZW-1:0]          z_q, z_d;
    logic [IW-1:0]          i_q, i_d;
    logic                   zero_q, zero_d;
    logic [ANGLE_WIDTH-1:0] angle_q, angle_d;
    logic                   valid_q, valid_d;

    logic signed [XW-1:0]   w_sin_ext, w_cos_ext, w_x_sh, w_y_sh;
    logic [ZW-1:0]          w_atan;
    logic [ANGLE_WIDTH-1:0] w_angle_rnd;

    atan_rom #(
        .ANGLE_WIDTH (ANGLE_WIDTH),
        .GUARD       (GUARD),
        .ITERATIONS  (ITERATIONS)
    ) u_atan_rom (
        .i      (i_q),
        .atan_i (w_atan)
    );

    assign w_sin_ext   = {{2{sin_in[VALUE_WIDTH-1]}}, sin_in};
    assign w_cos_ext   = {{2{cos_in[VALUE_WIDTH-1]}}, cos_in};
    assign w_x_sh      = x_q >>> i_q;
    assign w_y_sh      = y_q >>> i_q;
    assign w_angle_rnd = ANGLE_WIDTH'((z_q + C_Z_ROUND) >> GUARD);

    assign ready     = (state_q == IDLE);
    assign valid     = valid_q;
    assign angle_out = angle_q;

    // Next-state, datapath and output decode for the vectoring controller
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        i_d     = i_q;
        zero_d  = zero_q;
        angle_d = angle_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    // Fold the left half-plane onto the right so the CORDIC
                    // only has to cover +/-90 degrees
                    if (cos_in[VALUE_WIDTH-1]) begin
                        x_d = -w_cos_ext;
                        y_d = -w_sin_ext;
                        z_d = C_Z_HALF;
                    end else begin
                        x_d = w_cos_ext;
                        y_d = w_sin_ext;
                        z_d = '0;
                    end
                    // A zero vector has no direction; report angle 0 for it
                    // instead of the sum of all micro-rotation angles
                    zero_d  = (sin_in == '0) && (cos_in == '0);
                    i_d     = '0;
                    state_d = ROTATE;
                end
            end
            ROTATE: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + w_y_sh;
                    y_d = y_q - w_x_sh;
                    z_d = z_q + w_atan;
                end else begin
                    x_d = x_q - w_y_sh;
                    y_d = y_q + w_x_sh;
                    z_d = z_q - w_atan;
                end
                i_d = i_q + IW'(1);
                if (i_q == IW'(ITERATIONS - 1)) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                angle_d = zero_q ? '0 : w_angle_rnd;
                valid_d = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            i_q     <= '0;
            zero_q  <= 1'b0;
            angle_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            i_q     <= i_d;
            zero_q  <= zero_d;
            angle_q <= angle_d;
            valid_q <= valid_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_trig_angle_finder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trig_angle_finder
//  Description : Directed self-checking bench for trig_angle_finder.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_angle_finder;

    localparam int C_A = 1 << 30;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [31:0] sin_in;
    logic signed [31:0] cos_in;
    logic               ready;
    logic               valid;
    logic [9:0]         angle_out;

    int n_cmp  = 0;
    int n_fail = 0;

    trig_angle_finder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sin_in    (sin_in),
        .cos_in    (cos_in),
        .ready     (ready),
        .valid     (valid),
        .angle_out (angle_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Modular distance of at most one code
    function automatic logic near(input logic [9:0] got, input int exp);
        int d;
        d = (int'(got) - exp + 2048) % 1024;
        return (d == 0) || (d == 1) || (d == 1023);
    endfunction

    // One transaction from a falling edge: latency counted in rising edges
    // after the accepting edge; ready sampled just after acceptance and at valid
    task automatic run(input logic signed [31:0] s, input logic signed [31:0] c,
                       output logic [9:0] ang, output int lat,
                       output logic rdy_after, output logic rdy_at_valid);
        int w;
        w = 0;
        while (ready !== 1'b1 && w < 40) begin
            @(negedge clk);
            w++;
        end
        sin_in = s;
        cos_in = c;
        start  = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        rdy_after = ready;
        lat       = 0;
        while (valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        ang          = angle_out;
        rdy_at_valid = ready;
    endtask

    logic [9:0] ang;
    int         lat;
    logic       ra, rv;
    int         vt[3];
    int         nv, nacc, cyc, extra;

    initial begin
        start  = 1'b0;
        sin_in = '0;
        cos_in = '0;
        rst_n  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_ready", {31'b0, ready}, 32'd1);
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_angle", {22'b0, angle_out}, 32'd0);

        // Cardinal angles, back to back
        run(0, C_A, ang, lat, ra, rv);
        check("card_0", {22'b0, ang}, 32'd0);
        check("card_0_lat", lat, 32'd13);
        check("card_0_busy", {31'b0, ra}, 32'd0);
        check("card_0_rdy", {31'b0, rv}, 32'd1);
        run(C_A, 0, ang, lat, ra, rv);
        check("card_90", {22'b0, ang}, 32'd256);
        check("card_90_lat", lat, 32'd13);
        run(0, -C_A, ang, lat, ra, rv);
        check("card_180", {22'b0, ang}, 32'd512);
        check("card_180_lat", lat, 32'd13);
        run(-C_A, 0, ang, lat, ra, rv);
        check("card_270", {22'b0, ang}, 32'd768);
        check("card_270_lat", lat, 32'd13);

        // Diagonals
        run(759250125, 759250125, ang, lat, ra, rv);
        check("diag_45", {31'b0, near(ang, 128)}, 32'd1);
        run(-759250125, -759250125, ang, lat, ra, rv);
        check("diag_225", {31'b0, near(ang, 640)}, 32'd1);

        // Just below the seam at zero
        run(-(1 << 16), C_A, ang, lat, ra, rv);
        check("wrap_seam", {31'b0, (ang == 10'd0) || (ang == 10'd1023)}, 32'd1);

        // Extremes
        run(32'sh8000_0000, 32'sh8000_0000, ang, lat, ra, rv);
        check("ext_minmin", {31'b0, near(ang, 640)}, 32'd1);
        run(0, C_A, ang, lat, ra, rv);
        run(C_A, 0, ang, lat, ra, rv);
        run(0, 0, ang, lat, ra, rv);
        check("ext_zero", {22'b0, ang}, 32'd0);
        run(0, 32'sh8000_0000, ang, lat, ra, rv);
        check("ext_negmax", {22'b0, ang}, 32'd512);

        // start held high: one acceptance per 14 cycles
        @(negedge clk);
        sin_in = C_A;
        cos_in = 0;
        start  = 1'b1;
        nacc   = 1;
        nv     = 0;
        cyc    = 0;
        while (nv < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (valid === 1'b1) begin
                vt[nv] = cyc;
                check("hold_angle", {22'b0, angle_out}, 32'd256);
                nv++;
                if (nv == 3) start = 1'b0;
            end
            if (start && ready === 1'b1) nacc++;
        end
        check("hold_results", nv, 32'd3);
        check("hold_accepts", nacc, 32'd3);
        check("hold_gap1", vt[1] - vt[0], 32'd14);
        check("hold_gap2", vt[2] - vt[1], 32'd14);

        // start pulse mid-ROTATE with different data is ignored
        sin_in = 0;
        cos_in = C_A;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        sin_in = -C_A;
        cos_in = 0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat   = 5;
        while (valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("midstart_angle", {22'b0, angle_out}, 32'd0);
        check("midstart_lat", lat, 32'd13);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid === 1'b1) extra++;
        end
        check("midstart_noqueue", extra, 32'd0);

        // Reset during iteration 5 aborts the computation
        run(C_A, 0, ang, lat, ra, rv);
        check("prereset_angle", {22'b0, ang}, 32'd256);
        sin_in = 0;
        cos_in = C_A;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_ready", {31'b0, ready}, 32'd1);
        check("abort_valid", {31'b0, valid}, 32'd0);
        check("abort_angle", {22'b0, angle_out}, 32'd0);
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid === 1'b1) extra++;
        end
        check("abort_nostale", extra, 32'd0);
        run(-C_A, 0, ang, lat, ra, rv);
        check("abort_fresh", {22'b0, ang}, 32'd768);
        check("abort_fresh_lat", lat, 32'd13);

        // Sweep of every code from a reference sin/cos model
        for (int k = 0; k < 1024; k++) begin
            real ph;
            logic signed [31:0] s, c;
            ph = 2.0 * 3.14159265358979323846 * real'(k) / 1024.0;
            s  = int'(real'(C_A) * $sin(ph));
            c  = int'(real'(C_A) * $cos(ph));
            run(s, c, ang, lat, ra, rv);
            if (lat >= 40) check("sweep_timeout", lat, 32'd13);
            if (!near(ang, k)) begin
                $display("sweep code %0d gave %0d", k, ang);
            end
            check("sweep", {31'b0, near(ang, k)}, 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
